// File: rtl/inst_mem_arbiter_pkg.sv
// rtl/inst_mem_arbiter_pkg.sv - shared types and requester ids for the instruction-memory arbiter
package inst_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   localparam logic REQ_LOADER = 1'b0;
   localparam logic REQ_FETCH  = 1'b1;

endpackage

// File: rtl/inst_mem_arbiter_rr_pick2.sv
// rtl/inst_mem_arbiter_rr_pick2.sv - combinational two-way round-robin / fixed-priority picker
module inst_mem_arbiter_rr_pick2
   import inst_mem_arbiter_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_valid
);

   always_comb begin
      any_valid = |valid;
      grant     = REQ_LOADER;
      if (valid == 2'b11) begin
         // Under contention the round-robin build hands over to whoever did not win last.
         grant = (ROUND_ROBIN != 0) ? ~last_grant : REQ_LOADER;
      end else if (valid[REQ_FETCH]) begin
         grant = REQ_FETCH;
      end
   end

endmodule

// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - shares the instruction-memory port between program loader and fetch
module inst_mem_arbiter
   import inst_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ROUND_ROBIN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_valid,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_data,
   output logic              r0_ready,
   input  logic              r1_valid,
   input  logic [ADDR_W-1:0] r1_addr,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_ready,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              r0_ready_q, r0_ready_d;
   logic              r1_ready_q, r1_ready_d;
   logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
   logic              pick;
   logic              any_valid;

   inst_mem_arbiter_rr_pick2 #(
      .ROUND_ROBIN(ROUND_ROBIN)
   ) u_pick (
      .valid      ({r1_valid, r0_valid}),
      .last_grant (last_grant_q),
      .grant      (pick),
      .any_valid  (any_valid)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      mem_valid_d  = mem_valid_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      r0_ready_d   = r0_ready_q;
      r1_ready_d   = r1_ready_q;
      r1_rdata_d   = r1_rdata_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               last_grant_d = pick;
               mem_valid_d  = 1'b1;
               mem_we_d     = (pick == REQ_LOADER);
               mem_addr_d   = (pick == REQ_LOADER) ? r0_addr : r1_addr;
               if (pick == REQ_LOADER) begin
                  mem_wdata_d = r0_data;
               end
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               if (mem_we_q) begin
                  r0_ready_d = 1'b1;
               end else begin
                  r1_ready_d = 1'b1;
                  r1_rdata_d = mem_rdata;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            // The requester still shows its old valid here, so no grant is evaluated.
            r0_ready_d = 1'b0;
            r1_ready_d = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= REQ_FETCH;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         r0_ready_q   <= 1'b0;
         r1_ready_q   <= 1'b0;
         r1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         mem_valid_q  <= mem_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         r0_ready_q   <= r0_ready_d;
         r1_ready_q   <= r1_ready_d;
         r1_rdata_q   <= r1_rdata_d;
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign r0_ready  = r0_ready_q;
   assign r1_ready  = r1_ready_q;
   assign r1_rdata  = r1_rdata_q;

endmodule
